// File: rtl/timer_arbiter.sv
// timer_arbiter: one shared interval counter, handed out round-robin to
// NUM_REQ requesters. The winner's interval is latched at grant time. The
// counter advances on count_enable ticks, and when the count finishes the
// owner gets a single-cycle done pulse.
// Optional build macro: TIMER_ARB_ABORT_EN. When it is defined, an owner
// that drops its request while counting gives up the counter and receives
// no done pulse.
module timer_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int NUM_CNT_BITS = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*NUM_CNT_BITS-1:0] interval,
  input  logic                            count_enable,
  output logic [NUM_REQ-1:0]              grant,
  output logic [NUM_REQ-1:0]              done,
  output logic                            busy,
  output logic [NUM_CNT_BITS-1:0]         count_out
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_CNT_BITS-1:0] CNT_ONE = 1;
  localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [NUM_CNT_BITS-1:0]   count_q, count_d;
  logic [NUM_CNT_BITS-1:0]   active_val_q, active_val_d;
  logic [NUM_REQ-1:0]        grant_q, grant_d;
  logic [NUM_REQ-1:0]        done_q, done_d;
  logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]          winner_q, winner_d;

  logic                      arb_found;
  logic [IDX_W-1:0]          arb_pick;
  logic [IDX_W-1:0]          arb_idx;
  logic [NUM_CNT_BITS-1:0]   arb_interval;

  // Round-robin search: the first request found after the last winner.
  always_comb begin
    arb_found = 1'b0;
    arb_pick  = '0;
    arb_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      arb_idx = IDX_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!arb_found && req[arb_idx]) begin
        arb_found = 1'b1;
        arb_pick  = arb_idx;
      end
    end
  end

  // Select the interval lane that belongs to the requester picked above.
  always_comb begin
    arb_interval = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (arb_pick == IDX_W'(j)) begin
        arb_interval = interval[j*NUM_CNT_BITS +: NUM_CNT_BITS];
      end
    end
  end

  // Next-state logic: grant in IDLE, count in COUNT, pulse done in DONE.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    active_val_d = active_val_q;
    grant_d      = grant_q;
    done_d       = '0;
    rr_ptr_d     = rr_ptr_q;
    winner_d     = winner_q;
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          active_val_d      = arb_interval;
          count_d           = '0;
          grant_d           = '0;
          grant_d[arb_pick] = 1'b1;
          winner_d          = arb_pick;
          state_d           = COUNT;
        end
      end
      COUNT: begin
`ifdef TIMER_ARB_ABORT_EN
        if (!req[winner_q]) begin
          state_d  = IDLE;
          grant_d  = '0;
          count_d  = '0;
          rr_ptr_d = winner_q;
        end else
`endif
        if (count_enable) begin
          if (count_q == active_val_q) begin
            count_d = '0;
            done_d  = grant_q;
            state_d = DONE;
          end else begin
            count_d = count_q + CNT_ONE;
          end
        end
      end
      DONE: begin
        rr_ptr_d = winner_q;
        grant_d  = '0;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        count_d = '0;
      end
    endcase
  end

  // State registers. The pointer resets to the last slot so that requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      active_val_q <= '0;
      grant_q      <= '0;
      done_q       <= '0;
      rr_ptr_q     <= PTR_RESET;
      winner_q     <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      active_val_q <= active_val_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      rr_ptr_q     <= rr_ptr_d;
      winner_q     <= winner_d;
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);
  assign count_out = count_q;

endmodule
